// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix result streamer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matrix_pkg;

    // Streamer control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Default word width of a matrix element
    localparam int DEFAULT_DW = 32;

    // Bit offset of word k inside a flat matrix bus of dw-bit words
    function automatic int word_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/matrix_tx_index_gen.sv
// Row/column walker producing the flat snapshot index of the next word to emit.
// Latency: counters advance one cycle after inc; nxt_* outputs are combinational.
// Backpressure: none; the caller pulses inc only on an accepted beat.
// Build option: MATRIX_TX_TRANSPOSE_EN selects column-major order (row counter innermost).
module matrix_tx_index_gen
    import matrix_pkg::*;
#(
    parameter int ROW = 4,
    parameter int COL = 4,
    parameter int IW  = ((ROW * COL) > 1) ? $clog2(ROW * COL) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic          is_last,
    output logic [IW-1:0] nxt_idx,
    output logic          nxt_is_last
);

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COL - 1);

    logic [RW-1:0] row_q, row_n;
    logic [CW-1:0] col_q, col_n;

    // Element address in the row-major snapshot, independent of walk order
    function automatic logic [IW-1:0] flat_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return IW'(r) * IW'(COL) + IW'(c);
    endfunction

    assign is_last     = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign nxt_idx     = flat_idx(row_n, col_n);
    assign nxt_is_last = (row_n == ROW_MAX) && (col_n == COL_MAX);

    // Next position in emission order; holds at the final element so it never wraps
    always_comb begin
        row_n = row_q;
        col_n = col_q;
        if (!is_last) begin
`ifdef MATRIX_TX_TRANSPOSE_EN
            if (row_q == ROW_MAX) begin
                row_n = '0;
                col_n = col_q + 1'b1;
            end else begin
                row_n = row_q + 1'b1;
            end
`else
            if (col_q == COL_MAX) begin
                col_n = '0;
                row_n = row_q + 1'b1;
            end else begin
                col_n = col_q + 1'b1;
            end
`endif
        end
    end

    // Position register: clear on a new stream, step on each accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr) begin
            row_q <= '0;
            col_q <= '0;
        end else if (inc) begin
            row_q <= row_n;
            col_q <= col_n;
        end
    end

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots a flat ROW x COL matrix on start and emits it one word per accepted beat.
// Latency: first word valid the cycle after start; 1 word/cycle with out_ready held high.
// Backpressure: out_ready low holds out_data/out_last; MATRIX_TX_TRANSPOSE_EN = column-major order.
module matrix_result_streamer
    import matrix_pkg::*;
#(
    parameter int ROW = 4,
    parameter int COL = 4,
    parameter int DW  = DEFAULT_DW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW*COL*DW-1:0] Data_in,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int N  = ROW * COL;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t state_q, state_n;

    logic          cap;
    logic          idx_clr;
    logic          idx_inc;
    logic          fin;
    logic          is_last;
    logic          nxt_is_last;
    logic [IW-1:0] nxt_idx;
    logic [DW-1:0] nxt_word;

    logic [DW-1:0] in_words [N];
    logic [DW-1:0] snap_q   [N];

    // Split the flat input bus into words
    for (genvar k = 0; k < N; k++) begin : g_split
        assign in_words[k] = Data_in[word_lsb(k, DW) +: DW];
    end

    assign busy = (state_q == STREAM);
    assign done = (state_q == DONE);

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and datapath strobes; start is honoured only from IDLE
    always_comb begin
        state_n = state_q;
        cap     = 1'b0;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_n = STREAM;
                    cap     = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (is_last) begin
                        state_n = DONE;
                        fin     = 1'b1;
                        idx_clr = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    matrix_tx_index_gen #(
        .ROW (ROW),
        .COL (COL),
        .IW  (IW)
    ) u_index_gen (
        .clk         (clk),
        .reset       (reset),
        .clr         (idx_clr),
        .inc         (idx_inc),
        .is_last     (is_last),
        .nxt_idx     (nxt_idx),
        .nxt_is_last (nxt_is_last)
    );

    // Select the snapshot word that follows the one currently presented
    always_comb begin
        nxt_word = '0;
        for (int k = 0; k < N; k++) begin
            if (IW'(k) == nxt_idx) begin
                nxt_word = snap_q[k];
            end
        end
    end

    // Snapshot registers: loaded only on an accepted start, so later Data_in changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= '0;
            end
        end else if (cap) begin
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= in_words[k];
            end
        end
    end

    // Output register: word 0 comes straight from Data_in so it is valid one cycle after start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (cap) begin
            out_data  <= in_words[0];
            out_valid <= 1'b1;
            out_last  <= (N == 1);
        end else if (fin) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (idx_inc) begin
            out_data  <= nxt_word;
            out_last  <= nxt_is_last;
        end
    end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed and randomized bench for matrix_result_streamer (4x4 and 1x1 instances).
// Latency: expects first word one cycle after start, one word per cycle with ready held high.
// Backpressure: drives constant, patterned and random out_ready; checks stall stability.
module tb_matrix_result_streamer;

    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int DW  = 32;
    localparam int N   = ROW * COL;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N*DW-1:0] data_in;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;

    logic            s_start;
    logic [DW-1:0]   s_data_in;
    logic [DW-1:0]   s_out_data;
    logic            s_out_valid;
    logic            s_out_ready;
    logic            s_out_last;
    logic            s_busy;
    logic            s_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mat [N];

    always #5 clk = ~clk;

    matrix_result_streamer #(.ROW(ROW), .COL(COL), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .Data_in   (data_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    matrix_result_streamer #(.ROW(1), .COL(1), .DW(DW)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (s_start),
        .Data_in   (s_data_in),
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_last  (s_out_last),
        .busy      (s_busy),
        .done      (s_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Which matrix element leaves at beat i
    function automatic int order(input int i);
`ifdef MATRIX_TX_TRANSPOSE_EN
        return (i % ROW) * COL + i / ROW;
`else
        return i;
`endif
    endfunction

    function automatic logic [N*DW-1:0] pack_mat();
        logic [N*DW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[k*DW +: DW] = mat[k];
        return f;
    endfunction

    // ready_mode: 0 always ready, 1 pattern 1,0,0,..., 2 random.
    // abort_at > 0 pulses reset once that many beats were accepted.
    task automatic run_stream(input int ready_mode, input bit mid_start,
                              input bit corrupt, input int abort_at);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] prev_data;
        bit            prev_stall;
        bit            rdy;
        bit            aborted;
        int            got;
        int            cyc;

        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(mat[order(i)]);

        data_in = pack_mat();
        start   = 1'b1;
        step();
        start   = 1'b0;
        check("first_valid", out_valid, 1'b1);
        check("busy_stream", busy, 1'b1);
        check("done_stream", done, 1'b0);
        if (corrupt) data_in = {N{32'hDEADBEEF}};

        got = 0; cyc = 0; prev_stall = 0; prev_data = '0; aborted = 0;
        while (got < N && cyc < 400) begin
            if (abort_at > 0 && got == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_valid", out_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_done", done, 1'b0);
                check("rst_last", out_last, 1'b0);
                check("rst_data", out_data, '0);
                #1;
                reset = 1'b0;
                aborted = 1;
                break;
            end
            if (prev_stall) check("stall_hold", out_data, prev_data);
            if (out_valid) check("last_flag", out_last, (got == N - 1));
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start     = (mid_start && got == 3);
            if (out_valid && rdy) begin
                check("data", out_data, exp_q[got]);
                got++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid;
                prev_data  = out_data;
            end
            step();
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;

        if (aborted) begin
            step();
            check("post_rst_idle", out_valid, 1'b0);
        end else begin
            check("beats", got, N);
            if (ready_mode == 0) check("throughput", cyc, N);
            check("done_pulse", done, 1'b1);
            check("busy_in_done", busy, 1'b0);
            check("valid_drop", out_valid, 1'b0);
            check("last_drop", out_last, 1'b0);
            // start offered during DONE must not launch a stream
            if (mid_start) start = 1'b1;
            step();
            start = 1'b0;
            check("done_once", done, 1'b0);
            check("idle_valid", out_valid, 1'b0);
            check("idle_busy", busy, 1'b0);
            if (mid_start) begin
                repeat (3) step();
                check("no_second_stream", out_valid, 1'b0);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        out_ready   = 1'b0;
        data_in     = '0;
        s_start     = 1'b0;
        s_data_in   = '0;
        s_out_ready = 1'b0;
        repeat (2) step();
        check("reset_valid", out_valid, 1'b0);
        check("reset_data", out_data, '0);
        check("reset_last", out_last, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;
        step();
        check("idle_no_start", out_valid, 1'b0);

        // Sequential data, full throughput
        for (int k = 0; k < N; k++) mat[k] = 32'h100 + k;
        run_stream(0, 0, 0, 0);

        // Backpressure pattern 1,0,0,...
        run_stream(1, 0, 0, 0);

        // Snapshot survives Data_in change; start mid-stream and in DONE ignored
        run_stream(0, 1, 1, 0);

        // Reset after beat 5, then fresh stream from word 0
        run_stream(0, 0, 0, 5);
        run_stream(0, 0, 0, 0);

        // Random data with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) mat[k] = $urandom;
            run_stream(2, 0, 0, 0);
        end

        // 1x1 instance: single beat carries last, waits for ready
        s_data_in = 32'hA5A5A5A5;
        s_start   = 1'b1;
        step();
        s_start   = 1'b0;
        check("one_valid", s_out_valid, 1'b1);
        check("one_last", s_out_last, 1'b1);
        check("one_data", s_out_data, 32'hA5A5A5A5);
        repeat (2) step();
        check("one_wait_valid", s_out_valid, 1'b1);
        check("one_wait_busy", s_busy, 1'b1);
        s_out_ready = 1'b1;
        step();
        s_out_ready = 1'b0;
        check("one_done", s_done, 1'b1);
        check("one_valid_drop", s_out_valid, 1'b0);
        step();
        check("one_done_once", s_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
